// File: rtl/axis_arbiter_n_if.sv
// axis_arbiter_n_if: per-channel slave streams, merged master stream and grant status.
interface axis_arbiter_n_if #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter int ID_W   = 3
);
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic [ID_W-1:0]          m_axis_tid;
  logic                     m_axis_tlast;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     grant_active;
  // slave: the arbiter, which sinks the s_axis channels
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tlast, m_axis_tvalid, grant_active
  );
  // master: the sources and downstream sink around the arbiter
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tlast, m_axis_tvalid, grant_active
  );
endinterface

// File: rtl/axis_arbiter_n.sv
// axis_arbiter_n: N-input AXI4-Stream arbiter, round-robin or fixed priority, optional
// tlast packet locking, registered output slice.
module axis_arbiter_n #(
  parameter int NUM_CH    = 5,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 3,
  parameter int PKT_MODE  = 0,
  parameter int PRIO_MODE = 0
) (
  input logic             clk,
  input logic             reset,
  axis_arbiter_n_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CH);
  if (ID_W < IDX_W || NUM_CH < 2 || NUM_CH > 16) begin : g_bad_param
    $error("axis_arbiter_n: NUM_CH must be 2..16 and ID_W >= clog2(NUM_CH)");
  end
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d, last_grant_q, last_grant_d, sel, cand;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [ID_W-1:0]   tid_q, tid_d;
  logic              tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic              out_free, accept, done_g;
  // descending scan so the nearest candidate is the last one to overwrite sel
  always_comb begin
    sel = '0;
    cand = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = (PRIO_MODE != 0) ? IDX_W'(k - 1) : IDX_W'((int'(last_grant_q) + k) % NUM_CH);
      if (bus.s_axis_tvalid[cand]) sel = cand;
    end
  end
  always_comb begin
    out_free     = !tvalid_q || bus.m_axis_tready;
    accept       = (state_q == GRANT) && bus.s_axis_tvalid[grant_idx_q] && out_free;
    done_g       = accept && (PKT_MODE == 0 || bus.s_axis_tlast[grant_idx_q]);
    state_d      = done_g ? IDLE : (state_q == IDLE && |bus.s_axis_tvalid) ? GRANT : state_q;
    grant_idx_d  = (state_q == IDLE) ? sel : grant_idx_q;
    last_grant_d = done_g ? grant_idx_q : last_grant_q;
    tvalid_d     = accept || (tvalid_q && !bus.m_axis_tready);
    tdata_d      = accept ? bus.s_axis_tdata[grant_idx_q*DATA_W +: DATA_W] : tdata_q;
    tid_d        = accept ? ID_W'(grant_idx_q) : tid_q;
    tlast_d      = accept ? (PKT_MODE == 0 || bus.s_axis_tlast[grant_idx_q]) : tlast_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      tdata_q      <= '0;
      tid_q        <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      tdata_q      <= tdata_d;
      tid_q        <= tid_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
    end
  end
  assign bus.s_axis_tready = (state_q == GRANT && out_free) ? NUM_CH'(1) << grant_idx_q : '0;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tid    = tid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.grant_active  = (state_q == GRANT);
endmodule

// File: tb/tb_axis_arbiter_n.sv
// tb_axis_arbiter_n: three arbiter configurations (RR/beat, RR/packet, priority/beat) driven by
// directed vectors; hand-computed beats are queued and checked by a separate monitor.
module tb_axis_arbiter_n;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axis_arbiter_n_if #(.NUM_CH(5), .DATA_W(32), .ID_W(3)) bus_a ();
  axis_arbiter_n_if #(.NUM_CH(5), .DATA_W(32), .ID_W(3)) bus_b ();
  axis_arbiter_n_if #(.NUM_CH(5), .DATA_W(32), .ID_W(3)) bus_c ();
  axis_arbiter_n #(.NUM_CH(5), .DATA_W(32), .ID_W(3), .PKT_MODE(0), .PRIO_MODE(0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  axis_arbiter_n #(.NUM_CH(5), .DATA_W(32), .ID_W(3), .PKT_MODE(1), .PRIO_MODE(0))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  axis_arbiter_n #(.NUM_CH(5), .DATA_W(32), .ID_W(3), .PKT_MODE(0), .PRIO_MODE(1))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic [2:0]  id;
    logic        last;
    int          cyc;
  } beat_t;
  beat_t exp_q[$];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          base;
  int          plen_b[5];
  logic [15:0] seq_a[5], seq_b[5], seq_c[5];
  logic        zero_chk, hold_chk, stall_chk, no3_chk, done;
  logic [31:0] prev_d;
  logic [2:0]  prev_id;

  // source model: channel i of instance n presents {n, i, beat index}; b's tlast closes every plen_b beats
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      bus_a.s_axis_tdata[i*32 +: 32] = {8'd0, 8'(i), seq_a[i]};
      bus_b.s_axis_tdata[i*32 +: 32] = {8'd1, 8'(i), seq_b[i]};
      bus_c.s_axis_tdata[i*32 +: 32] = {8'd2, 8'(i), seq_c[i]};
      bus_b.s_axis_tlast[i] = ((int'(seq_b[i]) + 1) % plen_b[i]) == 0;
    end
    bus_a.s_axis_tlast = '0;
    bus_c.s_axis_tlast = '0;
  end
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (reset) begin
        seq_a[i] <= '0;
        seq_b[i] <= '0;
        seq_c[i] <= '0;
      end else begin
        if (bus_a.s_axis_tvalid[i] && bus_a.s_axis_tready[i]) seq_a[i] <= seq_a[i] + 16'd1;
        if (bus_b.s_axis_tvalid[i] && bus_b.s_axis_tready[i]) seq_b[i] <= seq_b[i] + 16'd1;
        if (bus_c.s_axis_tvalid[i] && bus_c.s_axis_tready[i]) seq_c[i] <= seq_c[i] + 16'd1;
      end
    end
  end

  task automatic push_exp(input int inst, input int ch, input int k, input logic last, input int at_cyc);
    beat_t b;
    b.inst = inst;
    b.data = {8'(inst), 8'(ch), 16'(k)};
    b.id   = 3'(ch);
    b.last = last;
    b.cyc  = at_cyc;
    exp_q.push_back(b);
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  task automatic chk_beat(input int inst, input logic [31:0] d, input logic [2:0] id, input logic l);
    beat_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL beat: inst%0d data=%h tid=%0d cyc=%0d, expected no beat", inst, d, id, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.data !== d || e.id !== id || e.last !== l || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL beat: got inst%0d data=%h tid=%0d last=%0d cyc=%0d, expected inst%0d data=%h tid=%0d last=%0d cyc=%0d",
                 inst, d, id, l, cyc, e.inst, e.data, e.id, e.last, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.m_axis_tvalid && bus_a.m_axis_tready) chk_beat(0, bus_a.m_axis_tdata, bus_a.m_axis_tid, bus_a.m_axis_tlast);
    if (bus_b.m_axis_tvalid && bus_b.m_axis_tready) chk_beat(1, bus_b.m_axis_tdata, bus_b.m_axis_tid, bus_b.m_axis_tlast);
    if (bus_c.m_axis_tvalid && bus_c.m_axis_tready) chk_beat(2, bus_c.m_axis_tdata, bus_c.m_axis_tid, bus_c.m_axis_tlast);
    if (zero_chk) begin
      cmp("reset_zero_a", 64'({bus_a.s_axis_tready, bus_a.m_axis_tvalid, bus_a.m_axis_tlast, bus_a.m_axis_tid, bus_a.grant_active, bus_a.m_axis_tdata}), 64'd0);
      cmp("reset_zero_b", 64'({bus_b.s_axis_tready, bus_b.m_axis_tvalid, bus_b.m_axis_tlast, bus_b.m_axis_tid, bus_b.grant_active, bus_b.m_axis_tdata}), 64'd0);
      cmp("reset_zero_c", 64'({bus_c.s_axis_tready, bus_c.m_axis_tvalid, bus_c.m_axis_tlast, bus_c.m_axis_tid, bus_c.grant_active, bus_c.m_axis_tdata}), 64'd0);
    end
    if (hold_chk)
      cmp("bp_hold", 64'({bus_a.m_axis_tvalid, bus_a.s_axis_tready, bus_a.m_axis_tid, bus_a.m_axis_tdata}),
          64'({1'b1, 5'b0, prev_id, prev_d}));
    if (stall_chk)
      cmp("stall_hold", 64'({bus_b.grant_active, bus_b.s_axis_tready & 5'b11101}), 64'({1'b1, 5'b0}));
    if (no3_chk) cmp("prio_no_ch3", 64'(bus_c.s_axis_tready[3]), 64'd0);
    prev_d  = bus_a.m_axis_tdata;
    prev_id = bus_a.m_axis_tid;
    if (done) begin
      cmp("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic at(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    reset = 1'b1;
    {zero_chk, hold_chk, stall_chk, no3_chk, done} = '0;
    bus_a.s_axis_tvalid = '0;
    bus_b.s_axis_tvalid = '0;
    bus_c.s_axis_tvalid = '0;
    bus_a.m_axis_tready = 1'b1;
    bus_b.m_axis_tready = 1'b1;
    bus_c.m_axis_tready = 1'b1;
    foreach (plen_b[i]) plen_b[i] = 1;
    tick();
    at(2); zero_chk = 1'b1;
    at(3); zero_chk = 1'b0; reset = 1'b0;
    at(5);
    // round-robin, one beat per grant: 0,1,2,3,4,0 every 2 cycles, tlast forced high
    base = cyc;
    bus_a.s_axis_tvalid = 5'h1f;
    for (int j = 0; j < 6; j++) push_exp(0, j % 5, j / 5, 1'b1, base + 2 + 2 * j);
    at(base + 12); bus_a.s_axis_tvalid = '0;
    at(base + 15);
    // backpressure: beat k2 held for 10 cycles, k3 loads on the draining cycle
    base = cyc;
    bus_a.s_axis_tvalid = 5'b00100;
    push_exp(0, 2, 1, 1'b1, base + 2);
    push_exp(0, 2, 2, 1'b1, base + 13);
    push_exp(0, 2, 3, 1'b1, base + 14);
    at(base + 3);  bus_a.m_axis_tready = 1'b0;
    at(base + 5);  hold_chk = 1'b1;
    at(base + 13); hold_chk = 1'b0; bus_a.m_axis_tready = 1'b1;
    at(base + 14); bus_a.s_axis_tvalid = '0;
    at(base + 17);
    // packet lock: ch1 single beat sets last_grant=1, then ch2's 3-beat packet, then 0, 1
    base = cyc;
    bus_b.s_axis_tvalid = 5'b00010;
    push_exp(1, 1, 0, 1'b1, base + 2);
    at(base + 2); bus_b.s_axis_tvalid = '0;
    at(base + 4);
    base = cyc;
    plen_b[2] = 3;
    bus_b.s_axis_tvalid = 5'b00111;
    push_exp(1, 2, 0, 1'b0, base + 2);
    push_exp(1, 2, 1, 1'b0, base + 3);
    push_exp(1, 2, 2, 1'b1, base + 4);
    push_exp(1, 0, 0, 1'b1, base + 6);
    push_exp(1, 1, 1, 1'b1, base + 8);
    at(base + 8); bus_b.s_axis_tvalid = '0;
    at(base + 10);
    // stall: granted ch1 drops valid for 4 cycles mid-packet while ch0/ch3 wait
    base = cyc;
    plen_b[1] = 6;
    bus_b.s_axis_tvalid = 5'b00010;
    push_exp(1, 1, 2, 1'b0, base + 2);
    push_exp(1, 1, 3, 1'b0, base + 3);
    push_exp(1, 1, 4, 1'b0, base + 8);
    push_exp(1, 1, 5, 1'b1, base + 9);
    at(base + 3); bus_b.s_axis_tvalid = 5'b01001; stall_chk = 1'b1;
    at(base + 7); bus_b.s_axis_tvalid = 5'b01011;
    at(base + 9); bus_b.s_axis_tvalid = '0; stall_chk = 1'b0;
    at(base + 11);
    // reset mid-packet with a held output beat: discarded, next grant goes to ch0
    base = cyc;
    plen_b[3] = 4;
    bus_b.s_axis_tvalid = 5'b01000;
    push_exp(1, 3, 0, 1'b0, base + 2);
    push_exp(1, 3, 1, 1'b0, base + 3);
    at(base + 4); bus_b.m_axis_tready = 1'b0; reset = 1'b1;
    at(base + 5);
    reset = 1'b0;
    bus_b.m_axis_tready = 1'b1;
    zero_chk = 1'b1;
    bus_b.s_axis_tvalid = 5'b01001;
    push_exp(1, 0, 0, 1'b1, base + 7);
    at(base + 6); zero_chk = 1'b0;
    at(base + 7); bus_b.s_axis_tvalid = '0;
    at(base + 9);
    // fixed priority: ch0 starves ch3 until ch0 drops
    base = cyc;
    bus_c.s_axis_tvalid = 5'b01001;
    no3_chk = 1'b1;
    push_exp(2, 0, 0, 1'b1, base + 2);
    push_exp(2, 0, 1, 1'b1, base + 4);
    push_exp(2, 0, 2, 1'b1, base + 6);
    push_exp(2, 3, 0, 1'b1, base + 8);
    at(base + 6); bus_c.s_axis_tvalid = 5'b01000;
    at(base + 7); no3_chk = 1'b0;
    at(base + 8); bus_c.s_axis_tvalid = '0;
    at(base + 12);
    done = 1'b1;
  end
endmodule
